// File: rtl/rc5_key_schedule.sv
// RC5 key expansion: loads C key words, expands them into the T-word subkey
// table S, and serves S through two registered read ports for the decipher stage.
module rc5_key_schedule #(
  parameter  int W        = 32,
  parameter  int R        = 12,
  parameter  int B        = 16,
  localparam int T        = 2 * (R + 1),
  localparam int T_LENGTH = $clog2(T),
  localparam int C_RAW    = (8 * B + W - 1) / W,
  localparam int C        = (C_RAW < 1) ? 1 : C_RAW,
  localparam int C_LENGTH = ($clog2(C) < 1) ? 1 : $clog2(C)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic                iKey_we,
  input  logic [C_LENGTH-1:0] iKey_addr,
  input  logic [W-1:0]        iKey_word,
  input  logic [T_LENGTH-1:0] iS_address1,
  input  logic [T_LENGTH-1:0] iS_address2,
  output logic [W-1:0]        oS_sub_i1,
  output logic [W-1:0]        oS_sub_i2,
  output logic                oBusy,
  output logic                oDone,
  output logic [1:0]          dbg_state
);

  localparam int N        = 3 * ((T > C) ? T : C);
  localparam int K_LENGTH = $clog2(N);
  localparam int LOGW     = $clog2(W);

  localparam logic [63:0] PW64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                 (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                             64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] QW64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                 (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                             64'h9E37_79B9_7F4A_7C15;
  localparam logic [W-1:0] PW = PW64[W-1:0];
  localparam logic [W-1:0] QW = QW64[W-1:0];

  // Handshake: iStart is a level sampled only in IDLE/DONE; oDone stays high
  // until the next accepted iStart (dropping on that same edge) or reset.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT_S = 2'd1,
    MIX    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [W-1:0]        s_mem [T];
  logic [W-1:0]        l_mem [C];
  logic [W-1:0]        reg_a, reg_b, acc;
  logic [T_LENGTH-1:0] idx_i, idx_n;
  logic [C_LENGTH-1:0] idx_j;
  logic [K_LENGTH-1:0] cnt_k;
  logic                phase;

  logic                idle_like, key_ok;
  logic [W-1:0]        sum_a, a_new, ab_sum, sum_b, b_new;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LOGW-1:0] s);
    logic [2*W-1:0] t;
    t = {x, x} << s;
    return t[2*W-1:W];
  endfunction

  assign dbg_state = state;
  assign idle_like = (state == IDLE) || (state == DONE);
  assign key_ok    = idle_like && iKey_we && (32'(iKey_addr) < 32'(C));

  // Phase b sees A already updated by phase a through reg_a.
  assign sum_a  = s_mem[idx_i] + reg_a + reg_b;
  assign a_new  = rotl(sum_a, LOGW'(3));
  assign ab_sum = reg_a + reg_b;
  assign sum_b  = l_mem[idx_j] + ab_sum;
  assign b_new  = rotl(sum_b, ab_sum[LOGW-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (iStart) state_next = INIT_S;
      INIT_S:     if (idx_n == T_LENGTH'(T - 1)) state_next = MIX;
      MIX:        if (phase && (cnt_k == K_LENGTH'(N - 1))) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < T; t++) s_mem[t] <= '0;
      for (int c = 0; c < C; c++) l_mem[c] <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      acc       <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      idx_n     <= '0;
      cnt_k     <= '0;
      phase     <= 1'b0;
      oS_sub_i1 <= '0;
      oS_sub_i2 <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      oS_sub_i1 <= (32'(iS_address1) < 32'(T)) ? s_mem[iS_address1] : '0;
      oS_sub_i2 <= (32'(iS_address2) < 32'(T)) ? s_mem[iS_address2] : '0;
      oBusy     <= (state == INIT_S) || (state == MIX);
      oDone     <= (state == DONE) && !iStart;
      if (key_ok) l_mem[iKey_addr] <= iKey_word;
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            idx_n <= '0;
            idx_i <= '0;
            idx_j <= '0;
            cnt_k <= '0;
            reg_a <= '0;
            reg_b <= '0;
            phase <= 1'b0;
            acc   <= PW;
          end
        end
        INIT_S: begin
          s_mem[idx_n] <= acc;
          acc          <= acc + QW;
          idx_n        <= idx_n + 1'b1;
        end
        MIX: begin
          if (!phase) begin
            reg_a        <= a_new;
            s_mem[idx_i] <= a_new;
            phase        <= 1'b1;
          end else begin
            reg_b        <= b_new;
            l_mem[idx_j] <= b_new;
            idx_i        <= (idx_i == T_LENGTH'(T - 1)) ? '0 : idx_i + 1'b1;
            idx_j        <= (idx_j == C_LENGTH'(C - 1)) ? '0 : idx_j + 1'b1;
            cnt_k        <= cnt_k + 1'b1;
            phase        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_key_schedule.sv
// Bench for rc5_key_schedule at W=32/R=12/B=16: random keys against a
// software RC5 key-schedule model, plus timing, reset and read-port corners.
module tb_rc5_key_schedule;

  localparam int W  = 32;
  localparam int R  = 12;
  localparam int T  = 26;
  localparam int C  = 4;
  localparam int NM = 3 * ((T > C) ? T : C);
  localparam logic [31:0] PW = 32'hB7E15163;
  localparam logic [31:0] QW = 32'h9E3779B9;
  localparam int LAT = 183;

  logic        clk, rst;
  logic        iStart, iKey_we;
  logic [1:0]  iKey_addr;
  logic [31:0] iKey_word;
  logic [4:0]  iS_address1, iS_address2;
  logic [31:0] oS_sub_i1, oS_sub_i2;
  logic        oBusy, oDone;
  logic [1:0]  dbg_state;

  rc5_key_schedule dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iKey_we(iKey_we),
    .iKey_addr(iKey_addr), .iKey_word(iKey_word),
    .iS_address1(iS_address1), .iS_address2(iS_address2),
    .oS_sub_i1(oS_sub_i1), .oS_sub_i2(oS_sub_i2),
    .oBusy(oBusy), .oDone(oDone), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] key_m [C];
  logic [31:0] exp_s [T];
  logic [W-1:0] exp_q [$];
  logic [31:0] got1 [T];
  logic [31:0] got2 [T];
  logic [31:0] snap0, snap1, snap2;
  logic        busy_early;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int s);
    logic [63:0] t;
    t = {x, x} << (s % 32);
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int s);
    logic [63:0] t;
    t = {x, x} >> (s % 32);
    return t[31:0];
  endfunction

  // Textbook RC5 key schedule; the resulting table is queued for checking.
  task automatic model_expand();
    logic [31:0] l [C];
    logic [31:0] a, b;
    int i, j;
    for (int c = 0; c < C; c++) l[c] = key_m[c];
    for (int t = 0; t < T; t++) exp_s[t] = PW + 32'(t) * QW;
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < NM; k++) begin
      a = rotl32(exp_s[i] + a + b, 3);
      exp_s[i] = a;
      b = rotl32(l[j] + a + b, int'((a + b) % 32));
      l[j] = b;
      i = (i + 1) % T;
      j = (j + 1) % C;
    end
    for (int t = 0; t < T; t++) exp_q.push_back(exp_s[t]);
  endtask

  task automatic write_key();
    for (int c = 0; c < C; c++) begin
      iKey_we = 1'b1; iKey_addr = 2'(c); iKey_word = key_m[c];
      @(posedge clk); #1;
    end
    iKey_we = 1'b0;
  endtask

  task automatic do_start();
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
  endtask

  // Counts edges after the iStart edge until oDone, bounded; optionally
  // throws iStart/iKey_we noise at the block while it is mixing.
  task automatic wait_done(input bit inject, output int cyc);
    cyc = 0;
    while (oDone !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) busy_early = oBusy;
      if (cyc == T + 1) begin snap0 = oS_sub_i1; snap1 = oS_sub_i2; end
      if (cyc == T + 2) snap2 = oS_sub_i1;
      if (inject && cyc >= 40 && cyc <= 170) begin
        iStart = 1'($urandom_range(0, 1));
        iKey_we = 1'($urandom_range(0, 1));
        iKey_addr = 2'($urandom_range(0, 3));
        iKey_word = $urandom();
      end else begin
        iStart = 1'b0;
        iKey_we = 1'b0;
      end
    end
    iStart = 1'b0;
    iKey_we = 1'b0;
  endtask

  task automatic read_table();
    for (int t = 0; t < T; t++) begin
      iS_address1 = 5'(t);
      iS_address2 = 5'(T - 1 - t);
      @(posedge clk); #1;
      got1[t] = oS_sub_i1;
      got2[T - 1 - t] = oS_sub_i2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (oS_sub_i1 !== 32'h0) begin n_err++; $display("FAIL reset_s1 got %h want 0", oS_sub_i1); end
    n_vec++; if (oS_sub_i2 !== 32'h0) begin n_err++; $display("FAIL reset_s2 got %h want 0", oS_sub_i2); end
    n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", oBusy); end
    n_vec++; if (oDone !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", oDone); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_key();
    int cyc;
    logic [31:0] e, da, db;
    for (int c = 0; c < C; c++) key_m[c] = 32'h0;
    write_key();
    model_expand();
    iS_address1 = 5'd0;
    iS_address2 = 5'd1;
    do_start();
    wait_done(1'b0, cyc);
    n_vec++; if (busy_early !== 1'b1) begin n_err++; $display("FAIL zero_busy_early got %b want 1", busy_early); end
    n_vec++; if (snap0 !== PW) begin n_err++; $display("FAIL zero_init_s0 got %h want %h", snap0, PW); end
    n_vec++; if (snap1 !== 32'h5618CB1C) begin n_err++; $display("FAIL zero_init_s1 got %h want 5618cb1c", snap1); end
    n_vec++; if (snap2 !== 32'hBF0A8B1D) begin n_err++; $display("FAIL zero_mix_s0 got %h want bf0a8b1d", snap2); end
    n_vec++; if (cyc !== LAT) begin n_err++; $display("FAIL zero_latency got %0d want %0d", cyc, LAT); end
    n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL zero_busy_at_done got %b want 0", oBusy); end
    read_table();
    for (int t = 0; t < T; t++) begin
      e = exp_q.pop_front();
      n_vec++; if (got1[t] !== e) begin n_err++; $display("FAIL zero_tab1[%0d] got %h want %h", t, got1[t], e); end
      n_vec++; if (got2[t] !== e) begin n_err++; $display("FAIL zero_tab2[%0d] got %h want %h", t, got2[t], e); end
    end
    da = 32'hEEDBA521;
    db = 32'h6D8F4B15;
    for (int r = R; r >= 1; r--) begin
      db = rotr32(db - got1[2 * r + 1], int'(da % 32)) ^ da;
      da = rotr32(da - got1[2 * r], int'(db % 32)) ^ db;
    end
    db = db - got1[1];
    da = da - got1[0];
    n_vec++; if (da !== 32'h0) begin n_err++; $display("FAIL zero_decipher_a got %h want 0", da); end
    n_vec++; if (db !== 32'h0) begin n_err++; $display("FAIL zero_decipher_b got %h want 0", db); end
  endtask

  task automatic test_read_bounds();
    iS_address1 = 5'd25;
    iS_address2 = 5'd0;
    @(posedge clk); #1;
    n_vec++; if (oS_sub_i1 !== exp_s[25]) begin n_err++; $display("FAIL bounds_s25 got %h want %h", oS_sub_i1, exp_s[25]); end
    n_vec++; if (oS_sub_i2 !== exp_s[0]) begin n_err++; $display("FAIL bounds_s0 got %h want %h", oS_sub_i2, exp_s[0]); end
    iS_address1 = 5'd26;
    iS_address2 = 5'd31;
    @(posedge clk); #1;
    n_vec++; if (oS_sub_i1 !== 32'h0) begin n_err++; $display("FAIL bounds_addr26 got %h want 0", oS_sub_i1); end
    n_vec++; if (oS_sub_i2 !== 32'h0) begin n_err++; $display("FAIL bounds_addr31 got %h want 0", oS_sub_i2); end
  endtask

  task automatic test_random_key();
    int cyc;
    logic [31:0] e;
    for (int c = 0; c < C; c++) key_m[c] = $urandom();
    write_key();
    model_expand();
    do_start();
    wait_done(1'b0, cyc);
    n_vec++; if (cyc !== LAT) begin n_err++; $display("FAIL rand_latency got %0d want %0d", cyc, LAT); end
    read_table();
    for (int t = 0; t < T; t++) begin
      e = exp_q.pop_front();
      n_vec++; if (got1[t] !== e) begin n_err++; $display("FAIL rand_tab1[%0d] got %h want %h", t, got1[t], e); end
      n_vec++; if (got2[t] !== e) begin n_err++; $display("FAIL rand_tab2[%0d] got %h want %h", t, got2[t], e); end
    end
  endtask

  task automatic test_ignore_during_busy();
    int cyc;
    logic [31:0] e;
    for (int c = 0; c < C; c++) key_m[c] = $urandom();
    write_key();
    model_expand();
    do_start();
    wait_done(1'b1, cyc);
    n_vec++; if (cyc !== LAT) begin n_err++; $display("FAIL noise_latency got %0d want %0d", cyc, LAT); end
    read_table();
    for (int t = 0; t < T; t++) begin
      e = exp_q.pop_front();
      n_vec++; if (got1[t] !== e) begin n_err++; $display("FAIL noise_tab[%0d] got %h want %h", t, got1[t], e); end
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    logic [31:0] e;
    for (int c = 0; c < C; c++) key_m[c] = $urandom();
    write_key();
    model_expand();
    iS_address1 = 5'd3;
    iS_address2 = 5'd17;
    do_start();
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL areset_busy got %b want 0", oBusy); end
    n_vec++; if (oDone !== 1'b0) begin n_err++; $display("FAIL areset_done got %b want 0", oDone); end
    n_vec++; if (oS_sub_i1 !== 32'h0) begin n_err++; $display("FAIL areset_s1 got %h want 0", oS_sub_i1); end
    n_vec++; if (oS_sub_i2 !== 32'h0) begin n_err++; $display("FAIL areset_s2 got %h want 0", oS_sub_i2); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL areset_state got %0d want 0", dbg_state); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    write_key();
    do_start();
    wait_done(1'b0, cyc);
    n_vec++; if (cyc !== LAT) begin n_err++; $display("FAIL areset_latency got %0d want %0d", cyc, LAT); end
    read_table();
    for (int t = 0; t < T; t++) begin
      e = exp_q.pop_front();
      n_vec++; if (got1[t] !== e) begin n_err++; $display("FAIL areset_tab[%0d] got %h want %h", t, got1[t], e); end
    end
  endtask

  task automatic test_restart();
    int cyc;
    logic [31:0] e;
    n_vec++; if (oDone !== 1'b1) begin n_err++; $display("FAIL restart_pre_done got %b want 1", oDone); end
    for (int c = 0; c < C; c++) key_m[c] = $urandom();
    write_key();
    model_expand();
    do_start();
    n_vec++; if (oDone !== 1'b0) begin n_err++; $display("FAIL restart_done_drop got %b want 0", oDone); end
    wait_done(1'b0, cyc);
    n_vec++; if (cyc !== LAT) begin n_err++; $display("FAIL restart_latency got %0d want %0d", cyc, LAT); end
    read_table();
    for (int t = 0; t < T; t++) begin
      e = exp_q.pop_front();
      n_vec++; if (got1[t] !== e) begin n_err++; $display("FAIL restart_tab1[%0d] got %h want %h", t, got1[t], e); end
      n_vec++; if (got2[t] !== e) begin n_err++; $display("FAIL restart_tab2[%0d] got %h want %h", t, got2[t], e); end
    end
  endtask

  initial begin
    rst = 1'b0;
    iStart = 1'b0;
    iKey_we = 1'b0;
    iKey_addr = 2'd0;
    iKey_word = 32'h0;
    iS_address1 = 5'd0;
    iS_address2 = 5'd0;
    test_reset();
    test_zero_key();
    test_read_bounds();
    test_random_key();
    test_ignore_during_busy();
    test_async_reset();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
